// File: rtl/rv_core_pkg.sv
// Shared types and constants for the RV32I core front end.
// Pure declarations: no logic and no timing behaviour.
package rv_core_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    WAIT  = 2'b01,
    HOLD  = 2'b10,
    TRAP  = 2'b11
  } fetch_state_e;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SEL_BR    = 2'b01;
  localparam logic [1:0] PC_SEL_ALU   = 2'b10;
  localparam logic [1:0] PC_SEL_RSVD  = 2'b11;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [1:0] TRAP_NONE     = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL  = 2'b01;
  localparam logic [1:0] TRAP_MISALIGN = 2'b10;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC mux with fetch-target alignment check.
// Latency: combinational; backpressure: none.
module fetch_next_pc
  import rv_core_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] br_target,
  input  logic [31:0] alu_data,
  output logic [31:0] next_pc,
  output logic        misalign
);

  always_comb begin
    next_pc = pc + 32'd4;
    case (pc_sel)
      PC_SEL_BR:  next_pc = br_target;
      // JALR clears bit 0 of the computed target before the alignment check.
      PC_SEL_ALU: next_pc = {alu_data[31:1], 1'b0};
      default:    next_pc = pc + 32'd4;
    endcase
    misalign = next_pc[1];
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem request, holds the word until retire.
// Latency: grant->o_inst_vld >= 2 cycles; backpressure: holds o_inst while i_inst_rdy=0.
module fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic        o_inst_vld,
  input  logic        i_inst_rdy,
  input  logic        i_insn_vld,
  input  logic [1:0]  i_pc_sel,
  input  logic [31:0] i_br_target,
  input  logic [31:0] i_alu_data,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [1:0]   cause_q, cause_d;

  logic [31:0]  next_pc;
  logic         next_misalign;

  fetch_next_pc u_next_pc (
    .pc        (pc_q),
    .pc_sel    (i_pc_sel),
    .br_target (i_br_target),
    .alu_data  (i_alu_data),
    .next_pc   (next_pc),
    .misalign  (next_misalign)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= INST_NOP;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    cause_d    = cause_q;
    o_imem_req = 1'b0;
    o_inst_vld = 1'b0;
    o_trap     = 1'b0;

    case (state_q)
      FETCH: begin
        // Request is masked while reset is held so nothing is issued in the reset cycle.
        o_imem_req = ~i_reset;
        if (i_imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_imem_rvalid) begin
          inst_d  = i_imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        o_inst_vld = 1'b1;
        if (i_inst_rdy) begin
          // Faults leave the PC pointing at the offending instruction.
          if (!i_insn_vld) begin
            cause_d = TRAP_ILLEGAL;
            state_d = TRAP;
          end else if (next_misalign) begin
            cause_d = TRAP_MISALIGN;
            state_d = TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      TRAP: begin
        o_trap = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign o_imem_addr  = pc_q;
  assign o_pc         = pc_q;
  assign o_pc_four    = pc_q + 32'd4;
  assign o_inst       = inst_q;
  assign o_trap_cause = cause_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_vld;
  logic        inst_rdy;
  logic        insn_vld;
  logic [1:0]  pc_sel;
  logic [31:0] br_target;
  logic [31:0] alu_data;
  logic [31:0] pc;
  logic [31:0] pc_four;
  logic        trap;
  logic [1:0]  trap_cause;

  int n_checks = 0;
  int n_fails  = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_inst        (inst),
    .o_inst_vld    (inst_vld),
    .i_inst_rdy    (inst_rdy),
    .i_insn_vld    (insn_vld),
    .i_pc_sel      (pc_sel),
    .i_br_target   (br_target),
    .i_alu_data    (alu_data),
    .o_pc          (pc),
    .o_pc_four     (pc_four),
    .o_trap        (trap),
    .o_trap_cause  (trap_cause)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(imem_gnt && imem_rvalid));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_req_low", {31'b0, imem_req}, 32'd0);
    check("rst_pc", pc, 32'h100);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_vld", {31'b0, inst_vld}, 32'd0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    check("rst_cause", {30'b0, trap_cause}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_req_after", {31'b0, imem_req}, 32'd1);
    check("rst_addr_after", imem_addr, 32'h100);
  endtask

  // Grant after dly cycles, respond one cycle later; noise on ignored inputs meanwhile.
  task automatic do_fetch(input int dly, input logic [31:0] word, input logic [31:0] exp_addr);
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_addr);
    for (int i = 0; i < dly; i++) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      inst_rdy    = 1'b1;
      tick();
      check("stall_req", {31'b0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, exp_addr);
    end
    imem_rvalid = 1'b0;
    inst_rdy    = 1'b0;
    imem_gnt    = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("wait_req", {31'b0, imem_req}, 32'd0);
    check("wait_vld", {31'b0, inst_vld}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    check("hold_vld", {31'b0, inst_vld}, 32'd1);
    check("hold_inst", inst, word);
    check("hold_pc", pc, exp_addr);
    check("hold_pc_four", pc_four, exp_addr + 32'd4);
  endtask

  task automatic do_retire(input logic [1:0] sel, input logic [31:0] br, input logic [31:0] alu,
                           input logic legal);
    pc_sel    = sel;
    br_target = br;
    alu_data  = alu;
    insn_vld  = legal;
    inst_rdy  = 1'b1;
    tick();
    inst_rdy = 1'b0;
    insn_vld = 1'b1;
    pc_sel   = 2'b00;
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_rdy = 1'b0; insn_vld = 1'b1; pc_sel = 2'b00; br_target = 32'h0; alu_data = 32'h0;

    do_reset();

    // Sequential flow from RESET_PC.
    do_fetch(0, 32'h0050_0093, 32'h100);
    do_retire(2'b00, 32'h0, 32'h0, 1'b1);
    check("seq_addr", imem_addr, 32'h104);
    check("seq_req", {31'b0, imem_req}, 32'd1);

    // Delayed grant, then back-pressure in HOLD.
    do_fetch(3, 32'h0000_8067, 32'h104);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_inst", inst, 32'h0000_8067);
      check("bp_vld", {31'b0, inst_vld}, 32'd1);
    end
    do_retire(2'b10, 32'h0, 32'h205, 1'b1);
    check("jalr_addr", imem_addr, 32'h204);

    do_fetch(0, 32'h0000_0063, 32'h204);
    do_retire(2'b01, 32'h80, 32'h0, 1'b1);
    check("br_addr", imem_addr, 32'h80);

    // Misaligned JALR target traps and stays trapped.
    do_fetch(1, 32'h0000_0067, 32'h80);
    do_retire(2'b10, 32'h0, 32'h206, 1'b1);
    for (int i = 0; i < 3; i++) begin
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      check("mis_trap", {31'b0, trap}, 32'd1);
      check("mis_cause", {30'b0, trap_cause}, 32'd2);
      check("mis_req", {31'b0, imem_req}, 32'd0);
      check("mis_vld", {31'b0, inst_vld}, 32'd0);
      check("mis_pc", pc, 32'h80);
    end
    do_reset();

    // Illegal opcode trap.
    do_fetch(0, 32'hFFFF_FFFF, 32'h100);
    do_retire(2'b00, 32'h0, 32'h0, 1'b0);
    check("ill_trap", {31'b0, trap}, 32'd1);
    check("ill_cause", {30'b0, trap_cause}, 32'd1);
    check("ill_pc", pc, 32'h100);
    check("ill_req", {31'b0, imem_req}, 32'd0);
    do_reset();

    // Wrap at the top of the address space, then reserved select acts as PC+4.
    do_fetch(0, 32'h0000_006F, 32'h100);
    do_retire(2'b01, 32'hFFFF_FFFC, 32'h0, 1'b1);
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    do_fetch(0, 32'h0000_0013, 32'hFFFF_FFFC);
    check("top_pc_four", pc_four, 32'h0);
    do_retire(2'b00, 32'h0, 32'h0, 1'b1);
    check("wrap_addr", imem_addr, 32'h0);
    do_fetch(0, 32'h0000_0013, 32'h0);
    do_retire(2'b11, 32'h80, 32'h300, 1'b1);
    check("rsvd_addr", imem_addr, 32'h4);

    // Reset while a response is outstanding.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("wrst_req", {31'b0, imem_req}, 32'd0);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      check("wrst_vld", {31'b0, inst_vld}, 32'd0);
      check("wrst_inst", inst, 32'h0000_0013);
      check("wrst_req_hold", {31'b0, imem_req}, 32'd1);
    end
    do_fetch(0, 32'h0010_0113, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle RV32I core. It owns the program counter and issues one request at a time to instruction memory. It holds the returned word stable for the decoder and control unit, and advances the PC only when the current instruction retires. It consumes the control unit's `pc_sel` and instruction-valid outputs and traps on illegal instructions or misaligned fetch targets.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `i_clk`  in  1  core clock; all state changes on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `o_imem_req`  out  1  fetch request; held high until granted.
- `o_imem_addr`  out  32  fetch address, equal to the PC.
- `i_imem_gnt`  in  1  request accepted this cycle.
- `i_imem_rvalid`  in  1  read data valid.
- `i_imem_rdata`  in  32  instruction word.
- `o_inst`  out  32  instruction presented to decode and the control unit.
- `o_inst_vld`  out  1  `o_inst` and `o_pc` are valid.
- `i_inst_rdy`  in  1  datapath retires `o_inst` this cycle.
- `i_insn_vld`  in  1  control unit reports a legal opcode.
- `i_pc_sel`  in  2  next-PC select:
  - 00: PC+4
  - 01: `i_br_target`
  - 10: `i_alu_data`
  - 11: reserved, treated as PC+4.
- `i_br_target`  in  32  PC+imm, used for JAL and taken branches.
- `i_alu_data`  in  32  rs1+imm, used for JALR.
- `o_pc`  out  32  PC of `o_inst`.
- `o_pc_four`  out  32  `o_pc` + 4, used as the writeback value.
- `o_trap`  out  1  sticky fault indicator.
- `o_trap_cause`  out  2  fault cause:
  - 01: illegal instruction
  - 10: misaligned target.

## Operation
- FSM states: FETCH, WAIT, HOLD, TRAP.
- FETCH:
  - `o_imem_req`=1 and `o_imem_addr`=PC.
  - When `i_imem_gnt`=1, go to WAIT.
- WAIT:
  - `o_imem_req`=0.
  - When `i_imem_rvalid`=1, capture `i_imem_rdata` into the instruction register and go to HOLD.
- HOLD: `o_inst_vld`=1, and `o_inst`/`o_pc` are held stable. On `i_inst_rdy`=1:
  - If `i_insn_vld`=0: go to TRAP with cause 01; the PC is not updated.
  - Otherwise, form the next PC:
    - `i_pc_sel`=10: `i_alu_data` with bit 0 cleared.
    - `i_pc_sel`=01: `i_br_target`.
    - `i_pc_sel`=00 or 11: PC+4.
  - If bit 1 of the next PC is set: go to TRAP with cause 10; the PC is not updated.
  - Else load the next PC and go to FETCH.
- TRAP: `o_inst_vld`=0, `o_imem_req`=0, `o_trap`=1. The state is left only by reset.
- `i_inst_rdy` is ignored outside HOLD.
- `i_imem_rvalid` is ignored outside WAIT.
- `i_imem_gnt` is ignored outside FETCH.
- Arithmetic is 32-bit modulo. PC+4 from 32'hFFFF_FFFC wraps to 32'h0.
- The instruction register resets to 32'h0000_0013 (NOP).

## Timing
- Reset values:
  - state FETCH; PC=`RESET_PC`; `o_inst`=32'h0000_0013
  - `o_inst_vld`=0; `o_trap`=0; `o_trap_cause`=00
  - `o_imem_req`=0 during the reset cycle, then 1 on the first cycle after `i_reset` falls.
- Earliest `i_imem_rvalid` is the cycle after the grant. The minimum fetch-to-`o_inst_vld` latency is 2 cycles (grant in cycle N, rvalid in N+1, `o_inst_vld` in N+2).
- Retire throughput is at most one instruction per 3 cycles: HOLD→FETCH→WAIT→HOLD.
- The next PC is registered on the `i_inst_rdy` edge. The new `o_imem_addr` appears the following cycle.
- `i_imem_rvalid` in the same cycle as the grant is a protocol violation. Its behaviour is undefined; the bench asserts it never occurs.
- Reset during WAIT: the outstanding response is dropped. The memory side is reset by the same `i_reset`, so no stale rvalid follows.
- Reset takes priority over every transition, including the TRAP exit.

## Structure
- Shared package `rv_core_pkg` holds:
  - `fetch_state_e`
  - `pc_sel` encodings `PC_SEL_PLUS4`, `PC_SEL_BR`, `PC_SEL_ALU`
  - `INST_NOP`=32'h0000_0013
  - trap-cause constants `TRAP_ILLEGAL`, `TRAP_MISALIGN`.
- One sub-module, `fetch_next_pc`: a combinational next-PC mux with alignment check. Its outputs are `next_pc` and `misalign`.

## Test plan
- Reset with `RESET_PC`=32'h100, grant immediate, rvalid one cycle later returning 32'h00500093, `i_pc_sel`=00 → `o_pc`=32'h100, `o_pc_four`=32'h104, next `o_imem_addr`=32'h104.
- Grant delayed 3 cycles → `o_imem_req` and `o_imem_addr` stay stable throughout. Hold `i_inst_rdy`=0 for 5 cycles in HOLD → `o_inst` unchanged.
- JALR with `i_alu_data`=32'h205 → next PC 32'h204. Branch with `i_br_target`=32'h80 → next PC 32'h80.
- `i_alu_data`=32'h206 → `o_trap`=1, cause 10, `o_imem_req` stays 0. Assert `i_reset` → PC=`RESET_PC`, trap cleared.
- Retire with `i_insn_vld`=0 → `o_trap`=1, cause 01, `o_pc` unchanged.
- PC 32'hFFFFFFFC with `i_pc_sel`=00 → next `o_imem_addr`=32'h0. Reset asserted in WAIT → FETCH from `RESET_PC`, with `o_inst_vld`=0 until the new response returns.
